// File: rtl/rpn_sequencer_if.sv
// Operation request/response channel between the key/parse front end and the RPN sequencer.
// Handshake: an op is taken on the rising edge where op_valid & ready; done pulses once per taken op with err/result/depth valid.
interface rpn_sequencer_if #(
  parameter int N = 16
);
  logic [2:0]   op;
  logic [N-1:0] operand;
  logic         op_valid;
  logic         ready;
  logic         done;
  logic [1:0]   err;
  logic [N-1:0] result;
  logic [6:0]   depth;

  modport master (
    output op, operand, op_valid,
    input  ready, done, err, result, depth
  );

  modport slave (
    input  op, operand, op_valid,
    output ready, done, err, result, depth
  );
endinterface

// File: rtl/rpn_sequencer.sv
// Initiator side of the stack command bus: expands calculator ops into POP/TOP/PUS/ALT/CLR
// sequences on a shared tri-state data bus and tracks stack depth for under/overflow checks.
module rpn_sequencer #(
  parameter int N     = 16,
  parameter int DEPTH = 64,
  parameter int SC_N  = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  inout  wire  [N-1:0]    data_io,
  input  logic            is_empty_i,
  output logic [SC_N-1:0] cmd_o,
  output logic [2:0]      state_o,
  rpn_sequencer_if.slave  op_if
);

  localparam int DW = 7;

  localparam logic [SC_N-1:0] SC_NOP = SC_N'(0);
  localparam logic [SC_N-1:0] SC_PUS = SC_N'(1);
  localparam logic [SC_N-1:0] SC_POP = SC_N'(2);
  localparam logic [SC_N-1:0] SC_TOP = SC_N'(3);
  localparam logic [SC_N-1:0] SC_ALT = SC_N'(4);
  localparam logic [SC_N-1:0] SC_CLR = SC_N'(5);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_DROP = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_B   = 3'd1,
    S_RD_A   = 3'd2,
    S_SETTLE = 3'd3,
    S_WRITE  = 3'd4,
    S_CLRS   = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  operand_q, operand_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [N-1:0]  result_q, result_d;
  logic [1:0]    err_q, err_d;
  logic [1:0]    ecode_q, ecode_d;
  logic          done_q, done_d;

  logic [DW-1:0] depth_eff;
  logic          underflow, overflow;
  logic          op_is_bin;
  logic [N-1:0]  wr_val;

  // The stack is the authority on emptiness; an empty report wins over our count.
  assign depth_eff = is_empty_i ? '0 : depth_q;
  assign op_is_bin = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);

  always_comb begin
    underflow = 1'b0;
    overflow  = 1'b0;
    case (op_if.op)
      OP_ADD, OP_SUB, OP_MUL: underflow = (depth_eff < DW'(2));
      OP_NEG, OP_DROP:        underflow = (depth_eff == '0);
      OP_DUP: begin
        underflow = (depth_eff == '0);
        overflow  = (depth_eff == DW'(DEPTH));
      end
      OP_PUSH:                overflow  = (depth_eff == DW'(DEPTH));
      default: ;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_PUSH: wr_val = operand_q;
      OP_ADD:  wr_val = a_q + b_q;
      OP_SUB:  wr_val = a_q - b_q;
      OP_MUL:  wr_val = a_q * b_q;
      OP_NEG:  wr_val = -a_q;
      OP_DUP:  wr_val = a_q;
      default: wr_val = '0;
    endcase
  end

  // Only WRITE drives the bus; every other state leaves it to the stack.
  assign data_io = (state_q == S_WRITE) ? wr_val : {N{1'bz}};

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    a_d       = a_q;
    b_d       = b_q;
    depth_d   = depth_q;
    result_d  = result_q;
    err_d     = err_q;
    ecode_d   = ecode_q;
    done_d    = 1'b0;
    cmd_o     = SC_NOP;
    case (state_q)
      S_IDLE: begin
        if (is_empty_i) depth_d = '0;
        if (op_if.op_valid) begin
          op_d      = op_if.op;
          operand_d = op_if.operand;
          ecode_d   = ERR_OK;
          if (underflow) begin
            ecode_d = ERR_UNDER;
            state_d = S_ERR;
          end else if (overflow) begin
            ecode_d = ERR_OVER;
            state_d = S_ERR;
          end else begin
            case (op_if.op)
              OP_PUSH:                         state_d = S_WRITE;
              OP_ADD, OP_SUB, OP_MUL, OP_DROP: state_d = S_RD_B;
              OP_NEG, OP_DUP:                  state_d = S_RD_A;
              default:                         state_d = S_CLRS;
            endcase
          end
        end
      end
      S_RD_B: begin
        cmd_o   = SC_POP;
        state_d = (op_q == OP_DROP) ? S_SETTLE : S_RD_A;
      end
      S_RD_A: begin
        cmd_o   = SC_TOP;
        if (op_is_bin) b_d = data_io;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cmd_o = SC_NOP;
        if (op_q == OP_DROP) begin
          b_d     = data_io;
          depth_d = depth_q - DW'(1);
          err_d   = ERR_OK;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          a_d     = data_io;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if ((op_q == OP_PUSH) || (op_q == OP_DUP)) begin
          cmd_o   = SC_PUS;
          depth_d = depth_q + DW'(1);
        end else begin
          cmd_o   = SC_ALT;
          if (op_is_bin) depth_d = depth_q - DW'(1);
        end
        result_d = wr_val;
        err_d    = ERR_OK;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_CLRS: begin
        cmd_o    = SC_CLR;
        depth_d  = '0;
        result_d = '0;
        err_d    = ERR_OK;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        cmd_o   = SC_NOP;
        err_d   = ecode_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= OP_PUSH;
      operand_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      depth_q   <= '0;
      result_q  <= '0;
      err_q     <= ERR_OK;
      ecode_q   <= ERR_OK;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      a_q       <= a_d;
      b_q       <= b_d;
      depth_q   <= depth_d;
      result_q  <= result_d;
      err_q     <= err_d;
      ecode_q   <= ecode_d;
      done_q    <= done_d;
    end
  end

  assign state_o      = state_q;
  assign op_if.ready  = (state_q == S_IDLE);
  assign op_if.done   = done_q;
  assign op_if.err    = err_q;
  assign op_if.result = result_q;
  assign op_if.depth  = depth_q;

endmodule
